// File: rtl/cpu_pkg.sv
// Shared definitions for the immediate rotate encoder: operand geometry
// and FSM state encoding.
package cpu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int IMM_WIDTH  = 8;
    localparam int ROT_STEPS  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/imm_rotate_encoder_rotate_left_even.sv
// Combinational 32-bit rotate-left by an even amount (2*rot_i).
// Rotating left undoes the decoder's rotate-right, so the candidate
// immediate appears in the low byte when rot_i is a valid encoding.
module rotate_left_even
    import cpu_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [3:0]            rot_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    logic [4:0]                shamt;
    logic [2*DATA_WIDTH-1:0]   doubled;

    // Shift a doubled copy so the bits leaving the top reappear at the bottom.
    always_comb begin
        shamt    = {rot_i, 1'b0};
        doubled  = {data_i, data_i} << shamt;
        result_o = doubled[2*DATA_WIDTH-1:DATA_WIDTH];
    end

endmodule

// File: rtl/imm_rotate_encoder.sv
// Multi-cycle encoder from a 32-bit constant to the {rot, imm8} immediate
// form. One rotation candidate is tried per cycle, lowest rot first, so the
// first hit is the canonical (minimal-rot) encoding.
// Handshake: start is a request pulse sampled only in IDLE; busy is high
// while searching; done pulses for one cycle and the result outputs are
// held from that point until the next completion.
module imm_rotate_encoder
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic                  carry_in,
    output logic                  busy,
    output logic                  done,
    output logic                  valid,
    output logic [IMM_WIDTH-1:0]  imm8,
    output logic [3:0]            rot,
    output logic                  carry_out
);

    localparam logic [3:0] LAST_ROT = 4'(ROT_STEPS - 1);

    state_e                state_q;
    logic [3:0]            r_q;
    logic [DATA_WIDTH-1:0] v_q;
    logic                  c_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  valid_q;
    logic [IMM_WIDTH-1:0]  imm8_q;
    logic [3:0]            rot_q;
    logic                  carry_q;

    logic [DATA_WIDTH-1:0] cand;
    logic                  match;

    rotate_left_even u_rol (
        .data_i   (v_q),
        .rot_i    (r_q),
        .result_o (cand)
    );

    // A candidate fits when everything above the immediate field is zero.
    always_comb begin
        match = (cand[DATA_WIDTH-1:IMM_WIDTH] == '0);
    end

    // Controller: capture request, walk the rotation counter, register results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            r_q     <= 4'd0;
            v_q     <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            imm8_q  <= '0;
            rot_q   <= 4'd0;
            carry_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        v_q     <= value;
                        c_q     <= carry_in;
                        r_q     <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (match) begin
                        valid_q <= 1'b1;
                        imm8_q  <= cand[IMM_WIDTH-1:0];
                        rot_q   <= r_q;
                        // Zero rotation leaves C unchanged in the decoder;
                        // otherwise the carry is the result's top bit.
                        carry_q <= (r_q == 4'd0) ? c_q : v_q[DATA_WIDTH-1];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (r_q == LAST_ROT) begin
                        valid_q <= 1'b0;
                        imm8_q  <= '0;
                        rot_q   <= 4'd0;
                        carry_q <= c_q;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        r_q <= r_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign valid     = valid_q;
    assign imm8      = imm8_q;
    assign rot       = rot_q;
    assign carry_out = carry_q;

endmodule
